ps2_dir_rx: RTL



---
 rtl/maze_pkg.sv | 49 ++++
 rtl/ps2_clk_filter.sv | 52 +++++
 rtl/ps2_dir_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared scan codes, receiver states and direction decode for the maze input path
// Scan codes are PS/2 set 2; the decode helper maps one make/break code to a direction.
package maze_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } dir_hit_t;

  // Arrows only count behind an E0 prefix; WASD only without one.
  function automatic dir_hit_t decode_dir(input logic [7:0] code, input logic ext,
                                          input logic en_wasd);
    dir_hit_t r;
    r = '{hit: 1'b0, dir: UP};
    if (ext) begin
      case (code)
        SC_UP:    r = '{hit: 1'b1, dir: UP};
        SC_DOWN:  r = '{hit: 1'b1, dir: DOWN};
        SC_LEFT:  r = '{hit: 1'b1, dir: LEFT};
        SC_RIGHT: r = '{hit: 1'b1, dir: RIGHT};
        default:  r = '{hit: 1'b0, dir: UP};
      endcase
    end else if (en_wasd) begin
      case (code)
        SC_W:    r = '{hit: 1'b1, dir: UP};
        SC_S:    r = '{hit: 1'b1, dir: DOWN};
        SC_A:    r = '{hit: 1'b1, dir: LEFT};
        SC_D:    r = '{hit: 1'b1, dir: RIGHT};
        default: r = '{hit: 1'b0, dir: UP};
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 clock/data synchroniser, clock glitch filter and falling-edge strobe
// Shared by the receive path and any later host-to-device transmitter.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic          r_clk_meta, r_clk_sync;
  logic          r_data_meta, r_data_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt, r_filt_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_cnt       <= '0;
      r_filt      <= 1'b1;
      r_filt_d    <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= ps2_data;
      r_data_sync <= r_data_meta;
      r_filt_d    <= r_filt;
      // The filtered clock follows only after FILTER_LEN disagreeing samples in a row.
      if (r_clk_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_filt <= r_clk_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign fall   = r_filt_d & ~r_filt;
  assign data_s = r_data_sync;

endmodule

// File: rtl/ps2_dir_rx.sv
// rtl/ps2_dir_rx.sv - PS/2 keyboard receiver producing maze direction press pulses and held levels
// Frame FSM with parity/stop/timeout checks, E0/F0 prefix tracking and arrow/WASD decode.
module ps2_dir_rx
  import maze_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit EN_WASD        = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       up_p,
  output logic       down_p,
  output logic       left_p,
  output logic       right_p,
  output logic       up_h,
  output logic       down_h,
  output logic       left_h,
  output logic       right_h
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic      w_fall, w_data;
  dir_hit_t  w_dir;

  rx_state_t     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_ext, r_brk;
  logic [7:0]    r_scan_code;
  logic          r_scan_valid, r_frame_err;
  logic [3:0]    r_press, r_held;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .clr      (clr),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (w_fall),
    .data_s   (w_data)
  );

  assign w_dir = decode_dir(r_scan_code, r_ext, EN_WASD);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_scan_code  <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_press      <= '0;
      r_held       <= '0;
    end else begin
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_press      <= '0;
      // r_to_cnt holds cycles elapsed since the last fall, counting the fall cycle itself.
      if (w_fall) begin
        r_to_cnt <= TW'(1);
        case (r_state)
          IDLE: begin
            if (!w_data) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (w_data && (^{r_shift, r_parity})) begin
              r_scan_code  <= r_shift;
              r_scan_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end else if (r_state != IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_frame_err <= 1'b1;
          r_state     <= IDLE;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end

      if (r_scan_valid) begin
        if (r_scan_code == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_scan_code == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_dir.hit) begin
            if (r_brk) begin
              r_held[w_dir.dir] <= 1'b0;
            end else if (!r_held[w_dir.dir]) begin
              r_held[w_dir.dir]  <= 1'b1;
              r_press[w_dir.dir] <= 1'b1;
            end
          end
        end
      end
      // A bad frame drops any half-built prefix so the next byte is read fresh.
      if (r_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign scan_code  = r_scan_code;
  assign scan_valid = r_scan_valid;
  assign frame_err  = r_frame_err;
  assign up_p       = r_press[UP];
  assign down_p     = r_press[DOWN];
  assign left_p     = r_press[LEFT];
  assign right_p    = r_press[RIGHT];
  assign up_h       = r_held[UP];
  assign down_h     = r_held[DOWN];
  assign left_h     = r_held[LEFT];
  assign right_h    = r_held[RIGHT];

endmodule
